// File: rtl/p2s_serializer.sv
// Parallel-to-serial engine with sclk/latch generation for 595-style chains.
// Define P2S_CHAIN_EN to add s_in daisy-chain fill and q readback.
module p2s_serializer #(
  parameter int WIDTH     = 16,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] p_in,
`ifdef P2S_CHAIN_EN
  input  logic             s_in,
  output logic [WIDTH-1:0] q,
`endif
  output logic             ready,
  output logic             sdata,
  output logic             sclk,
  output logic             latch,
  output logic             done
);

  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DW-1:0]    r_div;
  logic [DW-1:0]    w_div_nxt;
  logic [BW-1:0]    r_bit;
  logic [BW-1:0]    w_bit_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shifted;
  logic             r_sdata;
  logic             r_sclk;
  logic             r_latch;
  logic             r_done;
  logic             w_sdata_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_fill;
  logic             w_first;
  logic             w_next_bit;
  logic             w_div_end;

`ifdef P2S_CHAIN_EN
  assign w_fill = s_in;
  assign q      = r_shift;
`else
  assign w_fill = 1'b0;
`endif

  // The output end is the MSB when MSB_FIRST, otherwise the LSB.
  assign w_shifted = (MSB_FIRST != 0)
                   ? {r_shift[WIDTH-2:0], w_fill}
                   : {w_fill, r_shift[WIDTH-1:1]};

  assign w_first    = (MSB_FIRST != 0) ? p_in[WIDTH-1]
                                       : p_in[0];
  assign w_next_bit = (MSB_FIRST != 0) ? w_shifted[WIDTH-1]
                                       : w_shifted[0];
  assign w_div_end  = (r_div == DIV_M1);

  always_comb begin
    w_next      = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_sdata_nxt = r_sdata;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next      = SHIFT_LO;
          w_load      = 1'b1;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_sdata_nxt = w_first;
        end
      end
      SHIFT_LO: begin
        if (w_div_end) begin
          w_next    = SHIFT_HI;
          w_div_nxt = '0;
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end
      SHIFT_HI: begin
        if (w_div_end) begin
          w_div_nxt = '0;
          // Shift on the last bit too, so q collects WIDTH s_in samples.
          w_shift   = 1'b1;
          if (r_bit != BIT_LAST) begin
            w_next      = SHIFT_LO;
            w_bit_nxt   = r_bit + BW'(1);
            w_sdata_nxt = w_next_bit;
          end else begin
            w_next      = LATCH;
            w_sdata_nxt = 1'b0;
          end
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end
      LATCH: begin
        if (w_div_end) begin
          w_next    = DONE;
          w_div_nxt = '0;
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_sdata <= 1'b0;
      r_sclk  <= 1'b0;
      r_latch <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      if (w_load) begin
        r_shift <= p_in;
      end else if (w_shift) begin
        r_shift <= w_shifted;
      end
      r_sdata <= w_sdata_nxt;
      r_sclk  <= (w_next == SHIFT_HI);
      r_latch <= (w_next == LATCH);
      r_done  <= (w_next == DONE);
    end
  end

  assign ready = (r_state == IDLE);
  assign sdata = r_sdata;
  assign sclk  = r_sclk;
  assign latch = r_latch;
  assign done  = r_done;

endmodule
